axis_tpg_multi: RTL and testbench



---
 rtl/axis_tpg_multi_pkg.sv | 37 +++
 rtl/axis_tpg_pixel.sv | 70 +++++++
 rtl/axis_tpg_multi.sv | 176 +++++++++++++++++
 tb/tb_axis_tpg_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tpg_multi_pkg.sv
// Shared types and helpers for the AXI4-Stream test-pattern generator.
// Holds the pattern enum, the FSM state type and the full-scale bar palette.
package axis_tpg_multi_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [2:0] {
    TPG_BARS     = 3'd0,
    TPG_CHECKER  = 3'd1,
    TPG_HRAMP    = 3'd2,
    TPG_VRAMP    = 3'd3,
    TPG_BOX      = 3'd4,
    TPG_SOLID    = 3'd5,
    TPG_INV_BARS = 3'd6,
    TPG_BORDER   = 3'd7
  } tpg_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tpg_state_e;

  // SMPTE-style bar order, full-scale 8-bit {R,G,B}.
  function automatic logic [23:0] bar_rgb888(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/axis_tpg_pixel.sv
// Combinational pixel function: colour of coordinate (x, y) for the selected pattern.
// Output is packed {R,G,B}, R in the MSBs.
module axis_tpg_pixel
  import axis_tpg_multi_pkg::*;
#(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int R_WIDTH    = 5,
  parameter int G_WIDTH    = 6,
  parameter int B_WIDTH    = 5,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  localparam int DATA_WIDTH = R_WIDTH + G_WIDTH + B_WIDTH
) (
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  input  tpg_mode_e             mode,
  input  logic [COORD_W-1:0]    box_x,
  input  logic [COORD_W-1:0]    box_y,
  input  logic [DATA_WIDTH-1:0] color,
  output logic [DATA_WIDTH-1:0] pixel
);

  localparam int BAR_W = H_RES / 8;
  localparam logic [DATA_WIDTH-1:0] WHITE = '1;
  localparam logic [DATA_WIDTH-1:0] BLACK = '0;
  localparam logic [DATA_WIDTH-1:0] BLUE  = DATA_WIDTH'({B_WIDTH{1'b1}});

  logic [2:0]            bar_idx;
  logic [23:0]           bar_rgb;
  logic [DATA_WIDTH-1:0] bar_pix;
  logic                  in_box;
  logic                  on_border;

  // Channel LSBs below the target width are deliberately dropped.
  logic unused_rgb_bits;
  assign unused_rgb_bits = ^bar_rgb;

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= i * BAR_W) bar_idx = 3'(i);
    end
  end

  assign bar_rgb = bar_rgb888(bar_idx);
  assign bar_pix = {bar_rgb[23 -: R_WIDTH], bar_rgb[15 -: G_WIDTH], bar_rgb[7 -: B_WIDTH]};

  assign in_box = (int'(x) >= int'(box_x)) && (int'(x) < int'(box_x) + BOX_SIZE) &&
                  (int'(y) >= int'(box_y)) && (int'(y) < int'(box_y) + BOX_SIZE);

  assign on_border = (x == '0) || (x == COORD_W'(H_RES - 1)) ||
                     (y == '0) || (y == COORD_W'(V_RES - 1));

  always_comb begin
    pixel = BLACK;
    case (mode)
      TPG_BARS:     pixel = bar_pix;
      TPG_CHECKER:  pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? WHITE : BLACK;
      TPG_HRAMP:    pixel = {x[7 -: R_WIDTH], x[7 -: G_WIDTH], x[7 -: B_WIDTH]};
      TPG_VRAMP:    pixel = {y[7 -: R_WIDTH], y[7 -: G_WIDTH], y[7 -: B_WIDTH]};
      TPG_BOX:      pixel = in_box ? WHITE : BLUE;
      TPG_SOLID:    pixel = color;
      TPG_INV_BARS: pixel = ~bar_pix;
      TPG_BORDER:   pixel = on_border ? WHITE : BLACK;
      default:      pixel = BLACK;
    endcase
  end

endmodule

// File: rtl/axis_tpg_multi.sv
// AXI4-Stream video test-pattern generator: FSM, raster counters, bouncing box and output register.
// Define AXIS_TPG_STATUS_EN to build the frame and backpressure status counters.
module axis_tpg_multi
  import axis_tpg_multi_pkg::*;
#(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int R_WIDTH    = 5,
  parameter int G_WIDTH    = 6,
  parameter int B_WIDTH    = 5,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  localparam int DATA_WIDTH = R_WIDTH + G_WIDTH + B_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [2:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] color_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           stall_cnt_o
);

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] BOX_X_LIM = COORD_W'(H_RES - BOX_SIZE);
  localparam logic [COORD_W-1:0] BOX_Y_LIM = COORD_W'(V_RES - BOX_SIZE);

  tpg_state_e            state_reg, state_next;
  tpg_mode_e             mode_reg, mode_next;
  logic [COORD_W-1:0]    x_reg, x_next, y_reg, y_next;
  logic [COORD_W-1:0]    box_x_reg, box_x_next, box_y_reg, box_y_next;
  logic                  box_x_dec_reg, box_x_dec_next, box_y_dec_reg, box_y_dec_next;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg, tlast_reg, tuser_reg;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  handshake, frame_end, load;

  // Returns {decrementing, next position} for one bounce step of one axis.
  function automatic logic [COORD_W:0] box_step(input logic dec, input logic [COORD_W-1:0] pos,
                                                input logic [COORD_W-1:0] lim);
    if (!dec) return (pos == lim) ? {1'b1, pos - COORD_W'(1)} : {1'b0, pos + COORD_W'(1)};
    else      return (pos == '0)  ? {1'b0, pos + COORD_W'(1)} : {1'b1, pos - COORD_W'(1)};
  endfunction

  assign handshake = tvalid_reg && m_axis_tready;
  assign frame_end = handshake && (x_reg == X_LAST) && (y_reg == Y_LAST);

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    load       = 1'b0;
    {box_x_dec_next, box_x_next} = {box_x_dec_reg, box_x_reg};
    {box_y_dec_next, box_y_next} = {box_y_dec_reg, box_y_reg};
    if (frame_end) begin
      {box_x_dec_next, box_x_next} = box_step(box_x_dec_reg, box_x_reg, BOX_X_LIM);
      {box_y_dec_next, box_y_next} = box_step(box_y_dec_reg, box_y_reg, BOX_Y_LIM);
    end
    case (state_reg)
      ST_IDLE: begin
        if (en_i) begin
          state_next = ST_RUN;
          mode_next  = tpg_mode_e'(mode_i);
          x_next     = '0;
          y_next     = '0;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          x_next    = '0;
          y_next    = '0;
          mode_next = tpg_mode_e'(mode_i);
          if (en_i) load = 1'b1;
          else      state_next = ST_IDLE;
        end else if (handshake) begin
          load = 1'b1;
          if (x_reg == X_LAST) begin
            x_next = '0;
            y_next = y_reg + COORD_W'(1);
          end else begin
            x_next = x_reg + COORD_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The pixel is computed from the next coordinate so the output register can load it directly.
  axis_tpg_pixel #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .R_WIDTH    (R_WIDTH),
    .G_WIDTH    (G_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .CHECK_LOG2 (CHECK_LOG2),
    .BOX_SIZE   (BOX_SIZE)
  ) u_pixel (
    .x     (x_next),
    .y     (y_next),
    .mode  (mode_next),
    .box_x (box_x_next),
    .box_y (box_y_next),
    .color (color_i),
    .pixel (pixel)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= TPG_BARS;
      x_reg         <= '0;
      y_reg         <= '0;
      box_x_reg     <= '0;
      box_y_reg     <= '0;
      box_x_dec_reg <= 1'b0;
      box_y_dec_reg <= 1'b0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      tuser_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      box_x_reg     <= box_x_next;
      box_y_reg     <= box_y_next;
      box_x_dec_reg <= box_x_dec_next;
      box_y_dec_reg <= box_y_dec_next;
      if (load) begin
        tdata_reg  <= pixel;
        tlast_reg  <= (x_next == X_LAST);
        tuser_reg  <= (x_next == '0) && (y_next == '0);
        tvalid_reg <= 1'b1;
      end else if (handshake) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tuser  = tuser_reg;

`ifdef AXIS_TPG_STATUS_EN
  logic [15:0] frame_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (frame_end) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (tvalid_reg && !m_axis_tready && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`else
  assign frame_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axis_tpg_multi.sv
// Directed bench for axis_tpg_multi on a 16x8 raster with RGB565 pixels and a 4-pixel box.
// Status counter checks follow AXIS_TPG_STATUS_EN.
module tb_axis_tpg_multi;

  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [15:0] color = 16'hA5C3;
  logic [15:0] tdata;
  logic        tvalid, tlast, tuser;
  logic        tready = 1'b0;
  logic [15:0] fcnt, scnt;

  int n_cmp = 0;
  int n_err = 0;

  // Bench raster/box model.
  int ex = 0, ey = 0, emode = 0, bx = 0, by = 0;
  bit bxd = 0, byd = 0, running = 0;
  int frames = 0, stalls = 0;
  bit hold_v = 0;
  logic [15:0] hold_d;
  int first_white = 99;
  int box_log[$];
  int cyc;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  int box_exp [26] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                       11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  axis_tpg_multi #(
    .H_RES      (H),
    .V_RES      (V),
    .R_WIDTH    (5),
    .G_WIDTH    (6),
    .B_WIDTH    (5),
    .CHECK_LOG2 (2),
    .BOX_SIZE   (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .mode_i        (mode),
    .color_i       (color),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .frame_cnt_o   (fcnt),
    .stall_cnt_o   (scnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_pix(input int m, input int x, input int y);
    int bi;
    bi = x / 2;
    if (bi > 7) bi = 7;
    case (m)
      0: return bars[bi];
      1: return (((x >> 2) ^ (y >> 2)) & 1) != 0 ? 16'hFFFF : 16'h0000;
      2: return 16'((((x >> 3) & 31) << 11) | (((x >> 2) & 63) << 5) | ((x >> 3) & 31));
      3: return 16'((((y >> 3) & 31) << 11) | (((y >> 2) & 63) << 5) | ((y >> 3) & 31));
      4: return (x >= bx && x < bx + 4 && y >= by && y < by + 4) ? 16'hFFFF : 16'h001F;
      5: return color;
      6: return ~bars[bi];
      default: return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic model_frame_end();
    if (!bxd) begin
      if (bx == 12) begin bxd = 1; bx--; end else bx++;
    end else begin
      if (bx == 0) begin bxd = 0; bx++; end else bx--;
    end
    if (!byd) begin
      if (by == 4) begin byd = 1; by--; end else by++;
    end else begin
      if (by == 0) begin byd = 0; by++; end else by--;
    end
    if (emode == 4) box_log.push_back(first_white);
    first_white = 99;
    frames++;
    $display("frame %0d done: mode %0d, next box (%0d,%0d)", frames, emode, bx, by);
  endtask

  // Streams n accepted beats (or up to a frame end with en low), checking every beat.
  task automatic run_beats(input int n, input int pct, output int cycles);
    int acc = 0;
    cycles = 0;
    while (acc < n && running && cycles < n * 20 + 50) begin
      if (hold_v) check("stall_hold_tdata", tdata, hold_d);
      tready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (tvalid && tready) begin
        check("tuser", tuser, (ex == 0 && ey == 0));
        check("tlast", tlast, (ex == H - 1));
        check($sformatf("tdata_m%0d_x%0d_y%0d", emode, ex, ey), tdata, exp_pix(emode, ex, ey));
        if (emode == 4 && tdata == 16'hFFFF && ex < first_white) first_white = ex;
        acc++;
        hold_v = 0;
        if (ex == H - 1) begin
          ex = 0;
          if (ey == V - 1) begin
            ey = 0;
            model_frame_end();
            if (!en) running = 0;
            else emode = int'(mode);
          end else begin
            ey++;
          end
        end else begin
          ex++;
        end
      end else if (tvalid) begin
        stalls++;
        hold_v = 1;
        hold_d = tdata;
      end else begin
        hold_v = 0;
      end
      tick();
      cycles++;
    end
    if (acc < n && running) check("beat_timeout", acc, n);
  endtask

  task automatic check_status(input string tag);
`ifdef AXIS_TPG_STATUS_EN
    check({tag, "_frame_cnt"}, fcnt, frames);
    check({tag, "_stall_cnt"}, scnt, stalls);
`else
    check({tag, "_frame_cnt_off"}, fcnt, 0);
    check({tag, "_stall_cnt_off"}, scnt, 0);
`endif
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tuser", tuser, 0);
    check("rst_frame_cnt", fcnt, 0);
    check("rst_stall_cnt", scnt, 0);
    rst = 1'b0;
    tick();
    check("idle_tvalid", tvalid, 0);

    // Start: tvalid rises one cycle after en_i, first beat carries tuser
    en = 1'b1; mode = 3'd0; tready = 1'b1;
    tick();
    running = 1; emode = 0;
    check("start_tvalid", tvalid, 1);
    check("start_tuser", tuser, 1);
    run_beats(H * V, 100, cyc);
    check("frame_cycles_no_bubble", cyc, H * V);
    check("next_sof_tvalid", tvalid, 1);
    check("next_sof_tuser", tuser, 1);

    // Random backpressure: one more bars frame, then a horizontal-ramp frame
    mode = 3'd2;
    run_beats(2 * H * V, 60, cyc);
    check_status("backpressure");

    // Mode written mid-frame takes effect only at the next frame
    mode = 3'd1;
    run_beats(H * V, 100, cyc);
    run_beats(40, 70, cyc);
    mode = 3'd3;
    run_beats(H * V - 40, 70, cyc);
    mode = 3'd5;
    run_beats(H * V, 100, cyc);

    // en_i dropped mid-frame: frame completes, then idle
    run_beats(50, 100, cyc);
    en = 1'b0;
    run_beats(H * V, 100, cyc);
    for (int i = 0; i < 3; i++) begin
      check("drop_idle_tvalid", tvalid, 0);
      tick();
    end
    mode = 3'd6; en = 1'b1;
    tick();
    running = 1; emode = 6;
    check("restart_tvalid", tvalid, 1);
    check("restart_tuser", tuser, 1);
    mode = 3'd7;
    run_beats(H * V, 100, cyc);
    check_status("after_restart");

    // Reset asserted while beat (5,2) is presented
    mode = 3'd4;
    run_beats(2 * H + 5, 100, cyc);
    rst = 1'b1;
    tick();
    check("midrst_tvalid", tvalid, 0);
    check("midrst_tuser", tuser, 0);
    check("midrst_tlast", tlast, 0);
    check("midrst_frame_cnt", fcnt, 0);
    ex = 0; ey = 0; bx = 0; by = 0; bxd = 0; byd = 0;
    frames = 0; stalls = 0; hold_v = 0; first_white = 99;
    box_log.delete();
    rst = 1'b0;
    tick();
    running = 1; emode = 4;
    check("postrst_tvalid", tvalid, 1);
    check("postrst_tuser", tuser, 1);

    // Bouncing box over 26 frames
    run_beats(26 * H * V, 100, cyc);
    check("box_log_len", box_log.size(), 26);
    for (int i = 0; i < 26 && i < box_log.size(); i++)
      check($sformatf("box_x_frame%0d", i), box_log[i], box_exp[i]);
    check_status("box");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
